pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined, multi-mode barrel shifter for N-bit words: logical, arithmetic and rotate shifts, left or right, by 0..N-1 positions. It is the next generation of the team's combinational multi-directional shifter. The log2(N) shift levels are split into registered stages, and a valid/ready handshake on both sides allows one result per clock with back-pressure. It sits between a producer (ALU operand path or stream source) and a consumer that may stall.

---
 rtl/barrel_pkg.sv | 12 +
 rtl/shift_level.sv | 38 +++
 rtl/pipelined_barrel_shifter.sv | 116 +++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared encodings for the pipelined barrel shifter: shift modes and direction constants.
package barrel_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts data by 2^K when enabled.
module shift_level
  import barrel_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned K = 0
) (
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         lr,
  input  logic [1:0]   mode,
  input  logic         sign,
  output logic [N-1:0] q
);

  localparam int unsigned S = 2 ** K;

  always_comb begin
    q = d;
    if (en) begin
      if (lr == DIR_LEFT) begin
        // Arithmetic left is identical to logical left.
        if (mode == MODE_ROT || mode == MODE_RSVD) begin
          q = {d[N-S-1:0], d[N-1:N-S]};
        end else begin
          q = {d[N-S-1:0], {S{1'b0}}};
        end
      end else begin
        case (mode)
          MODE_LOGIC: q = {{S{1'b0}}, d[N-1:S]};
          MODE_ARITH: q = {{S{sign}}, d[N-1:S]};
          default:    q = {d[S-1:0], d[N-1:S]};
        endcase
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter: M shift levels grouped LVL_PER_STAGE per registered
// stage, with a valid/ready handshake and per-stage bubble collapse.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int unsigned N             = 32,
  parameter int unsigned M             = 5,
  parameter int unsigned LVL_PER_STAGE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [M-1:0] amt,
  input  logic         lr,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y
);

  localparam int unsigned L = (M + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

  // Stage s consumes src_* (operation input for stage 0, previous stage registers otherwise).
  logic [L-1:0][N-1:0] src_data;
  logic [L-1:0][M-1:0] src_amt;
  logic [L-1:0][1:0]   src_mode;
  logic [L-1:0]        src_lr;
  logic [L-1:0]        src_sign;
  logic [L-1:0]        src_v;
  logic [L-1:0]        v_vec;
  logic [L-1:0]        adv;
  logic [M-1:0][N-1:0] lvl_out;

  for (genvar k = 0; k < M; k++) begin : g_lvl
    localparam int unsigned S = k / LVL_PER_STAGE;
    logic [N-1:0] lvl_in;
    if (k % LVL_PER_STAGE == 0) begin : g_first
      assign lvl_in = src_data[S];
    end else begin : g_chain
      assign lvl_in = lvl_out[k-1];
    end
    shift_level #(
      .N (N),
      .K (k)
    ) u_level (
      .d    (lvl_in),
      .en   (src_amt[S][k]),
      .lr   (src_lr[S]),
      .mode (src_mode[S]),
      .sign (src_sign[S]),
      .q    (lvl_out[k])
    );
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int unsigned Last =
        ((s + 1) * LVL_PER_STAGE < M) ? (s + 1) * LVL_PER_STAGE - 1 : M - 1;

    logic [N-1:0] data_q;
    logic [M-1:0] amt_q;
    logic [1:0]   mode_q;
    logic         lr_q;
    logic         sign_q;
    logic         v_q;

    if (s == 0) begin : g_src
      assign src_data[s] = a;
      assign src_amt[s]  = amt;
      assign src_mode[s] = mode;
      assign src_lr[s]   = lr;
      assign src_sign[s] = a[N-1];
      assign src_v[s]    = in_valid;
    end else begin : g_src
      assign src_data[s] = g_stage[s-1].data_q;
      assign src_amt[s]  = g_stage[s-1].amt_q;
      assign src_mode[s] = g_stage[s-1].mode_q;
      assign src_lr[s]   = g_stage[s-1].lr_q;
      assign src_sign[s] = g_stage[s-1].sign_q;
      assign src_v[s]    = g_stage[s-1].v_q;
    end

    assign v_vec[s] = v_q;
    // A stage moves when the sink drains or any stage at or after it holds a bubble.
    assign adv[s]   = out_ready || !(&v_vec[L-1:s]);

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
        amt_q  <= '0;
        mode_q <= '0;
        lr_q   <= 1'b0;
        sign_q <= 1'b0;
        v_q    <= 1'b0;
      end else if (adv[s]) begin
        data_q <= lvl_out[Last];
        amt_q  <= src_amt[s];
        mode_q <= src_mode[s];
        lr_q   <= src_lr[s];
        sign_q <= src_sign[s];
        v_q    <= src_v[s];
      end
    end
  end

  // Amount bits already consumed and the last stage's sideband are never read.
  logic unused_ctrl;
  assign unused_ctrl = ^{src_amt, g_stage[L-1].amt_q, g_stage[L-1].mode_q,
                         g_stage[L-1].lr_q, g_stage[L-1].sign_q};

  assign in_ready  = adv[0];
  assign out_valid = v_vec[L-1];
  assign y         = g_stage[L-1].data_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised and directed bench for pipelined_barrel_shifter (N=32, M=5, 2 levels/stage).
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  amt;
  logic        lr;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(
    .N             (32),
    .M             (5),
    .LVL_PER_STAGE (2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .lr        (lr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          age;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  bit          lat_chk    = 1'b0;
  bit          rnd_bp     = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_y;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] n,
                                            input logic left, input logic [1:0] md);
    int s = int'(n);
    if (md[1]) begin
      if (left) return (x << s) | (x >> (32 - s));
      return (x >> s) | (x << (32 - s));
    end
    if (left) return x << s;
    if (md == 2'b01) return $unsigned($signed(x) >>> s);
    return x >> s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: evaluated mid-cycle, describing the transfers of the coming rising edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
    end else begin
      check_eq("in_ready", in_ready, (exp_q.size() < 3) || out_ready);
      check_eq("out_valid", out_valid, (exp_q.size() > 0) && (cyc - acc_q[0] >= 3));
      if (prev_stall) check_eq("stall_y", y, prev_y);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check_eq("y", y, exp_q.pop_front());
        age = cyc - acc_q.pop_front();
        if (lat_chk) check_eq("latency", age, 3);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(a, amt, lr, mode));
        acc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [31:0] ta, input logic [4:0] tamt, input logic tlr,
                      input logic [1:0] tmode);
    bit ok = 1'b0;
    a        = ta;
    amt      = tamt;
    lr       = tlr;
    mode     = tmode;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check_eq("accept", ok, 1);
  endtask

  task automatic drain();
    if (!rnd_bp) out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) idle(1);
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    amt       = '0;
    lr        = 1'b0;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_y", y, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Logical right sweep, back-to-back, fixed latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 32; i++) send(32'h0000_00F0, 5'(i), 1'b0, 2'b00);
    drain();
    lat_chk = 1'b0;

    // Sign fill and rotate corner cases.
    send(32'h8000_0000, 5'd4, 1'b0, 2'b01);
    send(32'h8000_0000, 5'd1, 1'b1, 2'b01);
    send(32'h1234_5678, 5'd8, 1'b1, 2'b10);
    send(32'h1234_5678, 5'd4, 1'b0, 2'b10);
    send(32'h1234_5678, 5'd4, 1'b0, 2'b11);
    send(32'hDEAD_BEEF, 5'd0, 1'b1, 2'b10);
    drain();

    // Back-pressure: consumer stalls while six operations stream in.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)));
      end
      begin
        idle(2);
        out_ready = 1'b0;
        idle(6);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight.
    send(32'hCAFE_F00D, 5'd3, 1'b1, 2'b00);
    send(32'h8765_4321, 5'd7, 1'b0, 2'b01);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_y", y, 0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(32'hF000_000F, 5'd5, 1'b0, 2'b01);
    drain();
    lat_chk = 1'b0;

    // Random operations with random gaps and random consumer stalls.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));
    end
    drain();
    rnd_bp    = 1'b0;
    out_ready = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
